// File: rtl/piso_tx_sched.sv
// Round-robin scheduler that feeds one shared piso shift register from NUM_REQ requesters.
// One word per frame: grant in IDLE, one LOAD cycle, then WIDTH+EXTRA_BITS SHIFT cycles.
module piso_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 42,
  parameter int EXTRA_BITS = 9,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     piso_load,
  output logic [WIDTH-1:0]         piso_data,
  output logic                     busy,
  output logic [ID_W-1:0]          active_id,
  output logic                     frame_done
);

  localparam int N     = WIDTH + EXTRA_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     r_ptr;

  logic                w_hit;
  logic [ID_W-1:0]     w_winner;
  logic [NUM_REQ-1:0]  w_grant;
  logic [WIDTH-1:0]    w_word;
  logic [NUM_REQ-1:0]  w_vshift;

  // Scan starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_hit    = 1'b0;
    w_winner = '0;
    w_vshift = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx      = (32'(r_ptr) + k) % NUM_REQ;
      w_vshift = req_valid >> idx;
      if (!w_hit && w_vshift[0]) begin
        w_hit    = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
    w_grant = w_hit ? (NUM_REQ'(1) << w_winner) : '0;
    w_word  = WIDTH'(req_data >> (32'(w_winner) * WIDTH));
  end

  // Gated by rst_n so no grant is advertised while reset is being held.
  assign req_ready = (rst_n && r_state == S_IDLE) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      piso_load  <= 1'b0;
      piso_data  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      active_id  <= '0;
      r_cnt      <= '0;
      r_ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            piso_data <= w_word;
            active_id <= w_winner;
            r_ptr     <= w_winner;
            piso_load <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          piso_load  <= 1'b0;
          piso_data  <= '0;
          r_cnt      <= CNT_LAST;
          frame_done <= (CNT_LAST == '0);
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          // frame_done is raised one edge early so it is high while the counter reads 0.
          if (r_cnt == '0) begin
            frame_done <= 1'b0;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt      <= r_cnt - CNT_W'(1);
            frame_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
